// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter in front of a single-port data memory.
// Master 0 is the core LSU, master 1 the secondary (trace/debug) port.
// One transaction is in flight at a time; a missing memory response is turned
// into an error response by a timeout counter (TIMEOUT_CYCLES=0 disables it).
// Optional build macro DATA_MEM_ARB_ROUND_ROBIN_EN: round-robin tie break
// instead of fixed priority (master 0 wins ties).
`timescale 1ns/1ps

module data_mem_arbiter #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [1:0]                          m_req_i,
   input  logic [1:0][ADDR_WIDTH-1:0]          m_addr_i,
   input  logic [1:0]                          m_we_i,
   input  logic [1:0][DATA_WIDTH/8-1:0]        m_be_i,
   input  logic [1:0][DATA_WIDTH-1:0]          m_wdata_i,
   output logic [1:0]                          m_gnt_o,
   output logic [1:0]                          m_rvalid_o,
   output logic [DATA_WIDTH-1:0]               m_rdata_o,
   output logic [1:0]                          m_err_o,
   output logic                                mem_req_o,
   output logic [ADDR_WIDTH-1:0]               mem_addr_o,
   output logic                                mem_we_o,
   output logic [DATA_WIDTH/8-1:0]             mem_be_o,
   output logic [DATA_WIDTH-1:0]               mem_wdata_o,
   input  logic                                mem_gnt_i,
   input  logic                                mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
   input  logic                                mem_err_i
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

   state_e                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   we_q, we_d;
   logic [BE_W-1:0]        be_q, be_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   winner;
   logic                   timeout_hit;

   // Last RESP cycle before the missing response is reported as an error
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
   // rr_q remembers the last granted master; a tie goes to the other one
   logic rr_q, rr_d;

   // Pick the winner: single requester wins outright, a tie goes to ~rr_q
   always_comb begin
      winner = ~m_req_i[0];
      if (m_req_i == 2'b11) begin
         winner = ~rr_q;
      end
      rr_d = rr_q;
      if (state_q == ST_REQ && mem_gnt_i) begin
         rr_d = owner_q;
      end
   end

   // Round-robin pointer; reset value 1 lets master 0 win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b1;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // Fixed priority: master 0 wins whenever it requests
   always_comb begin
      winner = ~m_req_i[0];
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and latched-transaction logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|m_req_i) begin
               owner_d = winner;
               addr_d  = m_addr_i[winner];
               we_d    = m_we_i[winner];
               be_d    = m_be_i[winner];
               wdata_d = m_wdata_i[winner];
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) begin
               cnt_d   = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_rvalid_i || timeout_hit) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Latched transaction, owner and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   // Outputs: memory side from the latched fields, master side routed to owner only
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      m_gnt_o     = 2'b00;
      m_rvalid_o  = 2'b00;
      m_err_o     = 2'b00;
      m_rdata_o   = '0;
      case (state_q)
         ST_REQ: begin
            mem_req_o        = 1'b1;
            mem_we_o         = we_q;
            mem_addr_o       = addr_q;
            mem_be_o         = be_q;
            mem_wdata_o      = wdata_q;
            m_gnt_o[owner_q] = mem_gnt_i;
         end
         ST_RESP: begin
            // Reads keep req high so the memory selects a read the cycle after gnt
            mem_req_o   = ~we_q;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_be_o    = be_q;
            mem_wdata_o = wdata_q;
            if (mem_rvalid_i) begin
               m_rvalid_o[owner_q] = 1'b1;
               m_err_o[owner_q]    = mem_err_i;
               m_rdata_o           = mem_rdata_i;
            end else if (timeout_hit) begin
               m_rvalid_o[owner_q] = 1'b1;
               m_err_o[owner_q]    = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a small
// behavioural memory (grant one cycle after req, response one cycle after grant).
`timescale 1ns/1ps

module tb_data_mem_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        m_req_i;
   logic [1:0][7:0]   m_addr_i;
   logic [1:0]        m_we_i;
   logic [1:0][3:0]   m_be_i;
   logic [1:0][31:0]  m_wdata_i;
   logic [1:0]        m_gnt_o, m_rvalid_o, m_err_o;
   logic [31:0]       m_rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [7:0]        mem_addr_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0]       mem_rdata_i;

   // Memory model state
   logic [31:0] mem [0:63];
   logic        init_done = 1'b0;
   logic        busy = 1'b0;
   logic        mdl_gnt = 1'b0, mdl_rv = 1'b0, mdl_err = 1'b0;
   logic [31:0] mdl_rdata = 32'h0;
   logic [5:0]  mdl_idx = 6'd0;
   logic        resp_en, err_en, tb_rv;

   int tests = 0;
   int fails = 0;
   int viol  = 0;

   // Captured per-transaction results
   logic [1:0]  t_gnt, t_rv, t_err;
   logic [3:0]  t_be;
   logic [7:0]  t_addr;
   logic        t_we, t_mreq1;
   logic [31:0] t_wd, t_rd;
   int          t_lat;

   assign mem_gnt_i    = mdl_gnt;
   assign mem_rvalid_i = mdl_rv | tb_rv;
   assign mem_rdata_i  = mdl_rdata;
   assign mem_err_i    = mdl_err;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .ADDR_WIDTH     (8),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m_req_i      (m_req_i),
      .m_addr_i     (m_addr_i),
      .m_we_i       (m_we_i),
      .m_be_i       (m_be_i),
      .m_wdata_i    (m_wdata_i),
      .m_gnt_o      (m_gnt_o),
      .m_rvalid_o   (m_rvalid_o),
      .m_rdata_o    (m_rdata_o),
      .m_err_o      (m_err_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_err_i    (mem_err_i)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Behavioural single-port memory
   always @(posedge clk) begin
      mdl_gnt <= 1'b0;
      mdl_rv  <= 1'b0;
      mdl_err <= 1'b0;
      if (!init_done) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
         mem[0] <= 32'hA5A5_0000;
         mem[1] <= 32'h1122_3344;
         init_done <= 1'b1;
      end
      if (!mem_req_o && !mem_we_o) begin
         busy <= 1'b0;
      end else if (!busy && mem_req_o) begin
         mdl_gnt <= 1'b1;
         busy    <= 1'b1;
         mdl_idx <= mem_addr_o[7:2];
         if (mem_we_o) mem[mem_addr_o[7:2]] <= merge(mem[mem_addr_o[7:2]], mem_wdata_o, mem_be_o);
      end
      if (mdl_gnt && resp_en) begin
         mdl_rv    <= 1'b1;
         mdl_rdata <= mem[mdl_idx];
         mdl_err   <= err_en;
      end
   end

   // At most one bit of each master-side vector may ever be set
   always @(negedge clk) begin
      if (rst_n && ($countones(m_gnt_o) > 1 || $countones(m_rvalid_o) > 1 ||
                    $countones(m_err_o) > 1)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_memctl"}, {18'h0, mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, 32'h0);
      check({tag, "_memwd"}, mem_wdata_o, 32'h0);
      check({tag, "_mflags"}, {26'h0, m_gnt_o, m_rvalid_o, m_err_o}, 32'h0);
      check({tag, "_mrdata"}, m_rdata_o, 32'h0);
   endtask

   // One complete transaction from master m, started and ended on an IDLE negedge
   task automatic do_txn(input int m, input logic we, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
      int c;
      m_req_i[m]   = 1'b1;
      m_we_i[m]    = we;
      m_addr_i[m]  = a;
      m_be_i[m]    = be;
      m_wdata_i[m] = wd;
      @(negedge clk);
      t_mreq1 = mem_req_o;
      c = 1;
      while (m_gnt_o == 2'b00 && c < 20) begin
         @(negedge clk);
         c++;
      end
      t_gnt  = m_gnt_o;
      t_addr = mem_addr_o;
      t_we   = mem_we_o;
      t_be   = mem_be_o;
      t_wd   = mem_wdata_o;
      m_req_i[m] = 1'b0;
      t_lat = 0;
      t_rv  = 2'b00;
      t_err = 2'b00;
      t_rd  = 32'h0;
      while (t_rv == 2'b00 && t_lat < 100) begin
         @(negedge clk);
         t_lat++;
         t_rv  = m_rvalid_o;
         t_err = m_err_o;
         t_rd  = m_rdata_o;
      end
      $display("[TB] txn m%0d we=%0d addr=%h be=%b gnt=%b rv=%b err=%b rdata=%h lat=%0d",
               m, we, a, be, t_gnt, t_rv, t_err, t_rd, t_lat);
      @(negedge clk);
   endtask

   initial begin
      int g0, g1, r0, r1, inflight_bad, c, nrv;
      logic req_gap;
      logic [31:0] rd1;
      logic [1:0] exp_rr [3];
      rst_n = 1'b0;
      m_req_i = 2'b00;
      m_addr_i = '0;
      m_we_i = 2'b00;
      m_be_i = '0;
      m_wdata_i = '0;
      resp_en = 1'b1;
      err_en = 1'b0;
      tb_rv = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous reads of 0x00: m0 first, m1 after m0 response plus one IDLE cycle
      g0 = -1; g1 = -1; r0 = -1; r1 = -1; inflight_bad = 0; req_gap = 1'b1; rd1 = 32'h0;
      m_req_i = 2'b11;
      m_we_i = 2'b00;
      m_addr_i = '0;
      m_be_i = {4'hF, 4'hF};
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (m_gnt_o[1] && r0 < 0) inflight_bad++;
         if (m_gnt_o[0] && g0 < 0) begin g0 = cyc; m_req_i[0] = 1'b0; end
         if (m_gnt_o[1] && g1 < 0) begin g1 = cyc; m_req_i[1] = 1'b0; end
         if (r0 >= 0 && cyc == r0 + 1) req_gap = mem_req_o;
         if (m_rvalid_o[0] && r0 < 0) r0 = cyc;
         if (m_rvalid_o[1] && r1 < 0) begin r1 = cyc; rd1 = m_rdata_o; end
         if (r1 >= 0) break;
      end
      m_req_i = 2'b00;
      $display("[TB] txn tie g0=%0d r0=%0d g1=%0d r1=%0d", g0, r0, g1, r1);
      check("tie_g0", g0, 2);
      check("tie_r0", r0, 3);
      check("tie_idle_gap", {31'h0, req_gap}, 32'h0);
      check("tie_g1", g1, 6);
      check("tie_r1", r1, 7);
      check("tie_rdata1", rd1, 32'hA5A5_0000);
      check("tie_inflight", inflight_bad, 0);
      @(negedge clk);

      // m0 write then read back 0x08
      do_txn(0, 1'b1, 8'h08, 4'hF, 32'hDEAD_BEEF);
      check("wr_req_lat", {31'h0, t_mreq1}, 32'h1);
      check("wr_gnt", {30'h0, t_gnt}, 32'h1);
      check("wr_memctl", {23'h0, t_we, t_addr}, {23'h0, 1'b1, 8'h08});
      check("wr_wdata", t_wd, 32'hDEAD_BEEF);
      check("wr_rv", {30'h0, t_rv}, 32'h1);
      do_txn(0, 1'b0, 8'h08, 4'hF, 32'h0);
      check("rd_gnt", {30'h0, t_gnt}, 32'h1);
      check("rd_rv", {30'h0, t_rv}, 32'h1);
      check("rd_err", {30'h0, t_err}, 32'h0);
      check("rd_rdata", t_rd, 32'hDEAD_BEEF);
      check("rd_lat", t_lat, 1);

      // m1 partial write of byte 1 at 0x04, then read back
      do_txn(1, 1'b1, 8'h04, 4'b0010, 32'h0000_AB00);
      check("bw_gnt", {30'h0, t_gnt}, 32'h2);
      check("bw_be", {28'h0, t_be}, 32'h2);
      check("bw_rv", {30'h0, t_rv}, 32'h2);
      do_txn(1, 1'b0, 8'h04, 4'hF, 32'h0);
      check("br_rv", {30'h0, t_rv}, 32'h2);
      check("br_rdata", t_rd, 32'h1122_AB44);

      // Memory error passes through to the owner
      err_en = 1'b1;
      do_txn(0, 1'b0, 8'h0C, 4'hF, 32'h0);
      err_en = 1'b0;
      check("merr_err", {30'h0, t_err}, 32'h1);
      check("merr_rdata", t_rd, 32'h1000_0003);

      // Timeout: memory grants but never answers
      resp_en = 1'b0;
      do_txn(0, 1'b0, 8'h10, 4'hF, 32'h0);
      check("to_rv", {30'h0, t_rv}, 32'h1);
      check("to_err", {30'h0, t_err}, 32'h1);
      check("to_rdata", t_rd, 32'h0);
      check("to_lat", t_lat, 4);
      tb_rv = 1'b1;
      #1;
      check("late_rv", {30'h0, m_rvalid_o}, 32'h0);
      @(negedge clk);
      tb_rv = 1'b0;

      // Reset during RESP of an m0 read
      m_req_i[0] = 1'b1;
      m_we_i[0] = 1'b0;
      m_addr_i[0] = 8'h08;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (m_gnt_o == 2'b00 && c < 20);
      check("rst_gnt", {30'h0, m_gnt_o}, 32'h1);
      m_req_i = 2'b00;
      @(negedge clk);
      check("rst_pre_req", {31'h0, mem_req_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      resp_en = 1'b1;
      nrv = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_rvalid_o != 2'b00) nrv++;
      end
      check("rst_no_rv", nrv, 0);
      do_txn(1, 1'b0, 8'h08, 4'hF, 32'h0);
      check("post_rst_gnt", {30'h0, t_gnt}, 32'h2);
      check("post_rst_rdata", t_rd, 32'hDEAD_BEEF);

      // Three back-to-back ties; losers withdraw once the winner is granted
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
`else
      exp_rr[0] = 2'b01; exp_rr[1] = 2'b01; exp_rr[2] = 2'b01;
`endif
      for (int rep = 0; rep < 3; rep++) begin
         m_req_i = 2'b11;
         m_we_i = 2'b00;
         m_addr_i = '0;
         c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (m_gnt_o == 2'b00 && c < 20);
         t_gnt = m_gnt_o;
         m_req_i = 2'b00;
         c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (m_rvalid_o == 2'b00 && c < 20);
         $display("[TB] txn rr rep=%0d gnt=%b rv=%b", rep, t_gnt, m_rvalid_o);
         check("rr_order", {30'h0, t_gnt}, {30'h0, exp_rr[rep]});
         @(negedge clk);
      end

      check("onehot_viol", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
